dir_input_encoder: RTL and testbench

DIR_INPUT_ENCODER -- requirements
Module: dir_input_encoder

---
 rtl/dir_input_encoder.sv | 135 +++++++++++++
 tb/tb_dir_input_encoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_encoder.sv
// Turns four raw pushbuttons into one-cycle direction commands for the game controller.
// Each button is synchronized and debounced; a command is followed by a lockout and a wait for release.
module dir_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [2:0]  dir,
  output logic        busy,
  output logic [15:0] cmd_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] DIR_IDLE = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LOCKOUT,
    S_WAIT_RELEASE
  } state_t;

  // Bit order doubles as command priority: up is bit 0 and wins.
  logic [3:0]         raw;
  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         deb_q, deb_d, deb_prev_q;
  logic [3:0]         evt_q;
  logic [3:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0]         code;

  state_t             state_q;
  logic [2:0]         dir_q;
  logic               busy_q;
  logic [15:0]        cmd_count_q;
  logic [LW-1:0]      lock_q;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    code = 3'd3;
    if (evt_q[0])      code = 3'd0;
    else if (evt_q[1]) code = 3'd1;
    else if (evt_q[2]) code = 3'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      evt_q      <= deb_q & ~deb_prev_q;
      cnt_q      <= cnt_d;
    end
  end

  // Press events are single-cycle pulses, so anything arriving outside IDLE is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_IDLE;
      busy_q      <= 1'b0;
      cmd_count_q <= '0;
      lock_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dir_q  <= DIR_IDLE;
          busy_q <= 1'b0;
          if (|evt_q) begin
            state_q     <= S_ISSUE;
            dir_q       <= code;
            busy_q      <= 1'b1;
            cmd_count_q <= cmd_count_q + 16'd1;
          end
        end
        S_ISSUE: begin
          state_q <= S_LOCKOUT;
          dir_q   <= DIR_IDLE;
          busy_q  <= 1'b1;
          lock_q  <= '0;
        end
        S_LOCKOUT: begin
          if (lock_q == LW'(LOCKOUT_CYCLES - 1)) begin
            state_q <= S_WAIT_RELEASE;
            busy_q  <= 1'b0;
          end else begin
            lock_q <= lock_q + 1'b1;
          end
        end
        S_WAIT_RELEASE: begin
          if (deb_q == 4'b0000) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          dir_q   <= DIR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dir       = dir_q;
  assign busy      = busy_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_dir_input_encoder.sv
// Bench for dir_input_encoder: expected commands are queued with the cycle they must appear on.
module tb_dir_input_encoder;

  localparam int DEB  = 4;
  localparam int LOCK = 48;
  localparam int LAT  = DEB + 4;  // drive time to dir cycle, counted in posedges

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [2:0]  dir;
  logic        busy;
  logic [15:0] cmd_count;

  typedef struct {
    logic [2:0]  code;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  dir_input_encoder #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .dir       (dir),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dir !== 3'd7) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_dir", 32'(dir), 32'd7);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("dir_code", 32'(dir), 32'(mon_e.code));
        check_val("dir_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [2:0] code, input int unsigned at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check_val(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    check_val("rst_dir", 32'(dir), 32'd7);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int unsigned r;

    // Outputs must stay at reset values while rst is held, even with a button pressed.
    btn_left = 1'b1;
    do_reset();
    btn_left = 1'b0;
    rst = 1'b1;
    tick(12);
    rst = 1'b0;

    // Single held press: one command, 49 busy cycles, no repeat while held.
    do_reset();
    btn_left = 1'b1;
    expect_cmd(3'd2, cyc + LAT);
    nb = 0;
    repeat (90) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    check_val("busy_cycles", nb, 49);
    check_val("count_left", 32'(cmd_count), 32'd1);
    drain("drain_left", 5);
    btn_left = 1'b0;
    tick(15);

    // Bounce shorter than the debounce window produces nothing.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_up = 1'b1;
      tick(2);
      btn_up = 1'b0;
      tick(2);
    end
    tick(20);
    check_val("bounce_count", 32'(cmd_count), 32'd0);
    check_val("bounce_busy", 32'(busy), 32'd0);

    // Simultaneous down and right: down wins, one command only.
    do_reset();
    btn_down  = 1'b1;
    btn_right = 1'b1;
    expect_cmd(3'd1, cyc + LAT);
    tick(70);
    check_val("simul_count", 32'(cmd_count), 32'd1);
    drain("drain_simul", 5);
    btn_down  = 1'b0;
    btn_right = 1'b0;
    tick(15);

    // Right pressed mid-lockout is discarded; a fresh press after release is accepted.
    do_reset();
    btn_up = 1'b1;
    expect_cmd(3'd0, cyc + LAT);
    tick(10);
    btn_up = 1'b0;
    tick(18);
    btn_right = 1'b1;
    tick(52);
    check_val("lockout_count", 32'(cmd_count), 32'd1);
    btn_right = 1'b0;
    tick(15);
    btn_right = 1'b1;
    expect_cmd(3'd3, cyc + LAT);
    tick(70);
    check_val("right_count", 32'(cmd_count), 32'd2);
    drain("drain_lockout", 5);
    btn_right = 1'b0;
    tick(15);

    // Reset during lockout aborts; the held button is re-debounced and reissued.
    do_reset();
    btn_left = 1'b1;
    expect_cmd(3'd2, cyc + LAT);
    tick(30);
    check_val("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_count", 32'(cmd_count), 32'd0);
    check_val("abort_dir", 32'(dir), 32'd7);
    rst = 1'b0;
    r = cyc;
    expect_cmd(3'd2, r + LAT);
    tick(70);
    check_val("reissue_count", 32'(cmd_count), 32'd1);
    drain("drain_abort", 5);
    btn_left = 1'b0;
    tick(15);

    // Counter wrap from 0xFFFF, then a further command still counts normally.
    do_reset();
    force dut.cmd_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.cmd_count_q;
    tick(1);
    check_val("preload_count", 32'(cmd_count), 32'h0000FFFF);
    btn_up = 1'b1;
    expect_cmd(3'd0, cyc + LAT);
    tick(70);
    check_val("wrap_count", 32'(cmd_count), 32'd0);
    btn_up = 1'b0;
    tick(15);
    btn_down = 1'b1;
    expect_cmd(3'd1, cyc + LAT);
    tick(70);
    check_val("post_wrap_count", 32'(cmd_count), 32'd1);
    drain("drain_wrap", 5);
    btn_down = 1'b0;
    tick(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
